// File: rtl/wb_arbiter.sv
// wb_arbiter: merges the single-cycle ALU writeback and the long-latency
// (load/MAC) writeback into one registered register-file write port.
// The ALU path always wins; long-latency results wait in a 2-entry FIFO.
// Optional feature: define WB_WAW_KILL_EN to let a newer ALU write to the
// same register invalidate an older pending long-latency result.
module wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_we,
  input  logic [4:0]  alu_addr,
  input  logic [31:0] alu_data,
  input  logic        lu_valid,
  input  logic [4:0]  lu_addr,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  output logic        we,
  output logic [4:0]  dst_addr,
  output logic [31:0] dst,
  output logic [1:0]  pend_cnt
);

  logic [1:0]  ent_valid;
  logic [4:0]  ent_addr [2];
  logic [31:0] ent_data [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;

  logic        alu_hit;
  logic        push;
  logic        pop;
  logic [1:0]  kill;
  logic [1:0]  valid_nxt;

  // Writes to r0 are meaningless, so a zero address never counts as a request.
  assign alu_hit  = alu_we && (alu_addr != 5'd0);
  assign lu_ready = (count < 2'd2);
  assign push     = lu_valid && lu_ready && (lu_addr != 5'd0);
  assign pop      = !alu_hit && (count != 2'd0);
  assign pend_cnt = count;

`ifdef WB_WAW_KILL_EN
  // A newer ALU write to a register makes any older pending result for it stale.
  always_comb begin
    kill = 2'b00;
    for (int i = 0; i < 2; i++) begin
      kill[i] = alu_hit && ent_valid[i] && (ent_addr[i] == alu_addr);
    end
  end
`else
  // Without the kill feature the compiler guarantees no write-after-write hazard.
  always_comb begin
    kill = 2'b00;
  end
`endif

  // Next valid bits: stale entries cleared, popped slot freed, pushed slot set.
  // The pushed slot is never an occupied one, so a same-cycle push is not killed.
  always_comb begin
    valid_nxt = ent_valid & ~kill;
    if (pop) begin
      valid_nxt[rd_ptr] = 1'b0;
    end
    if (push) begin
      valid_nxt[wr_ptr] = 1'b1;
    end
  end

  // Pending FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_valid <= 2'b00;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        ent_addr[i] <= 5'd0;
        ent_data[i] <= 32'd0;
      end
    end else begin
      ent_valid <= valid_nxt;
      if (push) begin
        ent_addr[wr_ptr] <= lu_addr;
        ent_data[wr_ptr] <= lu_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // Registered write port: ALU first, then FIFO head, otherwise idle and hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we       <= 1'b0;
      dst_addr <= 5'd0;
      dst      <= 32'd0;
    end else if (alu_hit) begin
      we       <= 1'b1;
      dst_addr <= alu_addr;
      dst      <= alu_data;
    end else if (pop) begin
      we       <= ent_valid[rd_ptr];
      dst_addr <= ent_addr[rd_ptr];
      dst      <= ent_data[rd_ptr];
    end else begin
      we       <= 1'b0;
    end
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 clk  input  1  Single clock; all state updates on rising edge.
REQ-002 rst  input  1  Asynchronous, active-high reset.
REQ-003 alu_we  input  1  Single-cycle-unit write request; cannot be stalled.
REQ-004 alu_addr  input  5  ALU destination register.
REQ-005 alu_data  input  32  ALU result.
REQ-006 lu_valid  input  1  Long-latency-unit (load/MAC) write request valid.
REQ-007 lu_addr  input  5  Long-latency-unit destination register.
REQ-008 lu_data  input  32  Long-latency-unit result.
REQ-009 lu_ready  output  1  Long-latency-unit request accepted this cycle when lu_valid & lu_ready.
REQ-010 we  output  1  Register-file write enable, registered.
REQ-011 dst_addr  output  5  Register-file write address, registered.
REQ-012 dst  output  32  Register-file write data, registered.
REQ-013 pend_cnt  output  2  Number of valid entries in the pending FIFO (0..2).

Function
REQ-014 Block merges two writeback sources into the single register-file write port; all three write outputs are flops updated every cycle.
REQ-015 Pending FIFO: 2 entries of {valid, addr[4:0], data[31:0]}; read/write pointers wrap modulo 2; occupancy 0..2.
REQ-016 lu_ready = (occupancy < 2); purely combinational from state, independent of lu_valid and alu_we.
REQ-017 Accepted LU request with lu_addr != 0 is pushed; accepted LU request with lu_addr == 0 is consumed and discarded (no push).
REQ-018 ALU request with alu_addr == 0 is treated as no request.
REQ-019 Arbitration each cycle: effective ALU request wins unconditionally -> next cycle we=1, dst_addr=alu_addr, dst=alu_data.
REQ-020 Otherwise, if FIFO non-empty: pop head; next cycle we = head.valid, dst_addr/dst = head fields.
REQ-021 Otherwise next cycle we=0; dst_addr and dst hold their previous values.
REQ-022 Push and pop in the same cycle permitted; push of the current-cycle request never pops in that cycle (minimum LU latency: accept at cycle N -> we at N+2).
REQ-023 Entries drain strictly in acceptance order.
REQ-024 ALU latency fixed at 1 cycle (request at N -> we at N+1).
REQ-025 pend_cnt reflects occupancy after the clock edge, including killed (valid=0) entries still occupying slots.
REQ-026 No overflow possible: push only when lu_ready=1; pop only when non-empty.

Reset
REQ-027 rst asserted: we=0, dst_addr=0, dst=0, pointers=0, occupancy=0, all entry valid bits=0, immediately and regardless of clk.
REQ-028 Requests presented during rst are ignored; in-flight FIFO contents are lost on reset mid-operation.
REQ-029 First accept possible on the first rising edge after rst deasserts; lu_ready=1 throughout reset.

Configuration
REQ-030 Macro WB_WAW_KILL_EN defined: effective ALU request with alu_addr equal to a valid FIFO entry's addr clears that entry's valid bit on the same edge (older LU value must not overwrite newer ALU value); killed entry still pops later, producing a we=0 cycle.
REQ-031 Same cycle LU push with lu_addr == alu_addr: pushed entry is not killed (LU is newer) when WB_WAW_KILL_EN is defined.
REQ-032 Macro undefined: no address comparison; every pushed entry pops with we=1 (ordering guaranteed by the compiler).

Verification
REQ-033 Reset: rst=1 mid-stream with 2 pending -> we=0, pend_cnt=0, lu_ready=1 immediately.
REQ-034 ALU only: alu_we=1 addr=5 data=0x1234_5678 at N -> we=1, dst_addr=5, dst=0x1234_5678 at N+1; addr=0 -> we=0.
REQ-035 Starvation/full: lu_valid=1 three consecutive cycles under continuous alu_we -> accepts 2, lu_ready=0 on third, pend_cnt=2; ALU drops -> two LU writes drain in order on consecutive cycles, lu_ready returns 1.
REQ-036 LU only: lu addr=7 data=0xA5A5_A5A5 accepted at N, no ALU -> we=1, dst_addr=7 at N+2; lu_addr=0 accepted -> no write, pend_cnt unchanged.
REQ-037 WAW with WB_WAW_KILL_EN: LU addr=3 pending, ALU write addr=3 data=0x1 -> reg 3 written 0x1, later pop cycle we=0; without macro -> LU value written after ALU value.
REQ-038 Simultaneous push/pop at occupancy 1 -> pend_cnt stays 1, FIFO order preserved across pointer wrap.
